cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor, the successor to the fixed 4-bit registered CLA. Operands are split into GROUP-bit lookahead groups. Each group resolves in its own pipeline stage, and the group carry is registered between stages, so clock rate is independent of WIDTH. The block accepts one operation per cycle under a valid flag, supports add/subtract mode, global stall, and signed-overflow reporting, and sits in the datapath wherever a registered N-bit adder is needed.

---
 rtl/cla_pipe_if.sv | 36 +++
 rtl/cla_pipe_adder.sv | 97 +++++++++
 tb/tb_cla_pipe_adder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_if.sv
// cla_pipe_if: operand/result bundle for cla_pipe_adder.
// Ports (signals):
//   stall     - freezes every pipeline register in the adder
//   in_valid  - a/b/cin/sub carry a new operation this cycle
//   a, b      - WIDTH-bit operands
//   cin       - carry-in (add mode only)
//   sub       - 0: a+b+cin, 1: a-b
//   out_valid - sum/cout/ovf hold a completed operation
//   sum       - WIDTH-bit result
//   cout      - carry out of the MSB (1 = no borrow in subtract mode)
//   ovf       - signed overflow
// master drives operations (the caller); slave is the adder.
interface cla_pipe_if #(
  parameter int WIDTH = 16
);
  logic             stall;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output stall, in_valid, a, b, cin, sub,
    input  out_valid, sum, cout, ovf
  );

  modport slave (
    input  stall, in_valid, a, b, cin, sub,
    output out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
// One GROUP-bit lookahead group is resolved per pipeline stage, with the
// group carry registered between stages, so cycle time does not grow with
// WIDTH. Latency is WIDTH/GROUP + 1 cycles, throughput one op per cycle.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset (overrides stall and in_valid)
//   bus - cla_pipe_if slave modport (operands in, registered results out)
// WIDTH must be a multiple of GROUP and at least GROUP.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic       clk,
  input  logic       rst,
  cla_pipe_if.slave  bus
);
  localparam int G = WIDTH / GROUP;

  // Stage k holds operand bits for groups not yet summed, the partial sum
  // of groups 0..k-1, and carry c(k) into group k. Stage G is the output.
  logic [G:0]       valid_q;
  logic [WIDTH-1:0] a_q   [0:G-1];
  logic [WIDTH-1:0] b_q   [0:G-1];
  logic [WIDTH-1:0] sum_q [0:G];
  logic [G:0]       c_q;
  logic             ovf_q;

  logic [WIDTH-1:0] sum_n [1:G];
  logic [G:1]       c_n;
  logic             c_msb_in;

  always_comb begin
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   cc;
    logic             t;
    logic             term;
    c_msb_in = 1'b0;
    for (int k = 1; k <= G; k++) begin
      p = a_q[k-1][(k-1)*GROUP +: GROUP] ^ b_q[k-1][(k-1)*GROUP +: GROUP];
      g = a_q[k-1][(k-1)*GROUP +: GROUP] & b_q[k-1][(k-1)*GROUP +: GROUP];
      cc = '0;
      cc[0] = c_q[k-1];
      // Two-level lookahead: carry i is c_in & p[0..i-1] or any g[j]
      // propagated through p[j+1..i-1]; no ripple through earlier carries.
      for (int i = 1; i <= GROUP; i++) begin
        t = c_q[k-1];
        for (int m = 0; m < i; m++) t = t & p[m];
        for (int j = 0; j < i; j++) begin
          term = g[j];
          for (int m = j + 1; m < i; m++) term = term & p[m];
          t = t | term;
        end
        cc[i] = t;
      end
      sum_n[k] = sum_q[k-1];
      sum_n[k][(k-1)*GROUP +: GROUP] = p ^ cc[GROUP-1:0];
      c_n[k] = cc[GROUP];
      if (k == G) c_msb_in = cc[GROUP-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < G; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k <= G; k++) sum_q[k] <= '0;
    end else if (!bus.stall) begin
      valid_q  <= {valid_q[G-1:0], bus.in_valid};
      a_q[0]   <= bus.a;
      b_q[0]   <= bus.sub ? ~bus.b : bus.b;
      c_q[0]   <= bus.sub | bus.cin;
      // Stage 0 has no result bits yet; keeps the forwarding uniform.
      sum_q[0] <= '0;
      for (int k = 1; k < G; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int k = 1; k <= G; k++) begin
        sum_q[k] <= sum_n[k];
        c_q[k]   <= c_n[k];
      end
      ovf_q <= c_msb_in ^ c_n[G];
    end
  end

  assign bus.out_valid = valid_q[G];
  assign bus.sum       = sum_q[G];
  assign bus.cout      = c_q[G];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vq[$];
  vec_t tab16[10];

  cla_pipe_if #(.WIDTH(16)) if16 ();
  cla_pipe_if #(.WIDTH(8))  if8  ();
  cla_pipe_if #(.WIDTH(32)) if32 ();

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  cla_pipe_adder #(.WIDTH(8),  .GROUP(8)) dut8  (.clk(clk), .rst(rst), .bus(if8));
  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the full operands.
  function automatic vec_t mk(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    longint unsigned m, lm, aa, bb, c0, full, low;
    vec_t v;
    m  = (64'd1 << w) - 1;
    lm = (64'd1 << (w - 1)) - 1;
    aa = a;
    aa = aa & m;
    bb = b;
    bb = bb & m;
    if (sub) bb = m ^ bb;
    c0 = (sub || cin) ? 64'd1 : 64'd0;
    full = aa + bb + c0;
    low  = (aa & lm) + (bb & lm) + c0;
    v.a   = aa[31:0];
    v.b   = b & m[31:0];
    v.cin = cin;
    v.sub = sub;
    v.s   = full[31:0] & m[31:0];
    v.co  = ((full >> w) & 64'd1) != 0;
    v.ov  = (((low >> (w - 1)) & 64'd1) != 0) ^ v.co;
    return v;
  endfunction

  task automatic drive(int sel, logic v, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    case (sel)
      0: begin if16.in_valid = v; if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = cin; if16.sub = sub; end
      1: begin if8.in_valid  = v; if8.a  = a[7:0];  if8.b  = b[7:0];  if8.cin  = cin; if8.sub  = sub; end
      default: begin if32.in_valid = v; if32.a = a; if32.b = b; if32.cin = cin; if32.sub = sub; end
    endcase
  endtask

  // {out_valid, ovf, cout, sum zero-extended}
  function automatic logic [34:0] rd(int sel);
    case (sel)
      0:       return {if16.out_valid, if16.ovf, if16.cout, 16'h0, if16.sum};
      1:       return {if8.out_valid,  if8.ovf,  if8.cout,  24'h0, if8.sum};
      default: return {if32.out_valid, if32.ovf, if32.cout, if32.sum};
    endcase
  endfunction

  // Issue every vector in vq on consecutive cycles and expect results exactly
  // lat edges after issue, in order, with no gaps and no extras.
  task automatic run_stream(int sel, int lat, string tag);
    int n;
    logic [34:0] r;
    n = vq.size();
    for (int t = 0; t <= n + lat; t++) begin
      if (t < n) drive(sel, 1'b1, vq[t].a, vq[t].b, vq[t].cin, vq[t].sub);
      else       drive(sel, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      r = rd(sel);
      if (t >= lat && t - lat < n) begin
        chk({tag, "_valid"}, {31'h0, r[34]}, 32'h1);
        chk({tag, "_sum"},   r[31:0], vq[t-lat].s);
        chk({tag, "_cout"},  {31'h0, r[32]}, {31'h0, vq[t-lat].co});
        chk({tag, "_ovf"},   {31'h0, r[33]}, {31'h0, vq[t-lat].ov});
      end else begin
        chk({tag, "_novalid"}, {31'h0, r[34]}, 32'h0);
      end
    end
  endtask

  initial begin
    logic [34:0] r;
    checks = 0;
    errors = 0;
    tab16[0] = '{32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0};
    tab16[1] = '{32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1};
    tab16[2] = '{32'h0003, 32'h0005, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0};
    tab16[3] = '{32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1};
    tab16[4] = '{32'h1234, 32'h4321, 1'b1, 1'b0, 32'h5556, 1'b0, 1'b0};
    tab16[5] = '{32'h0000, 32'h0000, 1'b0, 1'b1, 32'h0000, 1'b1, 1'b0};
    tab16[6] = '{32'h8000, 32'h8000, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b1};
    tab16[7] = '{32'hFFFF, 32'hFFFF, 1'b1, 1'b0, 32'hFFFF, 1'b1, 1'b0};
    tab16[8] = '{32'h0005, 32'h0005, 1'b1, 1'b1, 32'h0000, 1'b1, 1'b0};
    tab16[9] = '{32'h00FF, 32'h0001, 1'b0, 1'b0, 32'h0100, 1'b0, 1'b0};

    rst = 1'b1;
    if16.stall = 1'b0; if8.stall = 1'b0; if32.stall = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      r = rd(s);
      chk("rst_valid", {31'h0, r[34]}, 32'h0);
      chk("rst_sum",   r[31:0], 32'h0);
      chk("rst_cout",  {31'h0, r[32]}, 32'h0);
      chk("rst_ovf",   {31'h0, r[33]}, 32'h0);
    end
    rst = 1'b0;
    tick();

    // Directed table, streamed back to back.
    vq.delete();
    foreach (tab16[i]) vq.push_back(tab16[i]);
    run_stream(0, 4, "dir16");

    // Eight back-to-back ops mixing sub and cin.
    vq.delete();
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(16, $urandom, $urandom, i[1], i[0]));
    run_stream(0, 4, "rnd16");

    // Stall for 3 cycles while the op sits in stage 2.
    drive(0, 1'b1, 32'h1234, 32'h4321, 1'b1, 1'b0);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    if16.stall = 1'b1;
    drive(0, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      r = rd(0);
      chk("stall_hold_valid", {31'h0, r[34]}, 32'h0);
    end
    if16.stall = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    r = rd(0);
    chk("stall_early", {31'h0, r[34]}, 32'h0);
    tick();
    r = rd(0);
    chk("stall_out_valid", {31'h0, r[34]}, 32'h1);
    chk("stall_out_sum", r[31:0], 32'h5556);
    chk("stall_out_cout", {31'h0, r[32]}, 32'h0);
    if16.stall = 1'b1;
    tick();
    r = rd(0);
    chk("stall_frozen_valid", {31'h0, r[34]}, 32'h1);
    chk("stall_frozen_sum", r[31:0], 32'h5556);
    if16.stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      r = rd(0);
      chk("stall_no_phantom", {31'h0, r[34]}, 32'h0);
    end

    // Reset with three ops in flight; rst must beat stall and in_valid.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 32'h1111 * (i + 1), 32'h0101, 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    if16.stall = 1'b1;
    tick();
    r = rd(0);
    chk("midrst_valid", {31'h0, r[34]}, 32'h0);
    chk("midrst_sum",   r[31:0], 32'h0);
    chk("midrst_cout",  {31'h0, r[32]}, 32'h0);
    chk("midrst_ovf",   {31'h0, r[33]}, 32'h0);
    rst = 1'b0;
    if16.stall = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      r = rd(0);
      chk("midrst_gone", {31'h0, r[34]}, 32'h0);
    end
    vq.delete();
    vq.push_back(tab16[4]);
    run_stream(0, 4, "postrst16");

    // WIDTH=8, GROUP=8: single group, 2-cycle latency.
    vq.delete();
    vq.push_back('{32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0});
    vq.push_back('{32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1});
    vq.push_back('{32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1});
    for (int i = 0; i < 60; i++)
      vq.push_back(mk(8, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
    run_stream(1, 1, "w8");

    // WIDTH=32, GROUP=4: 8 groups, 9-cycle latency.
    vq.delete();
    vq.push_back('{32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
    vq.push_back('{32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});
    vq.push_back('{32'h3, 32'h5, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
    for (int i = 0; i < 40; i++)
      vq.push_back(mk(32, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
    run_stream(2, 8, "w32");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
